// File: rtl/acondicionador_botones.sv
`default_nettype none
// ============================================================================
// Module  : acondicionador_botones
// Brief   : multi-channel button sync -> debounce -> edge detect -> counter
// Rev     : 1.0
// ============================================================================
module acondicionador_botones #(
    parameter int N_CANALES      = 4,
    parameter int SYNC_ETAPAS    = 2,
    parameter int CICLOS_ESTABLE = 50000,
    parameter int ANCHO_CONTA    = 8,
    parameter int MODO           = 0
) (
    input  logic                             clk_i,
    input  logic                             reset_pi,
    input  logic [N_CANALES-1:0]             botones_pi,
    input  logic                             habilitar_pi,
    input  logic [N_CANALES-1:0]             limpiar_pi,
    output logic [N_CANALES-1:0]             estado_o,
    output logic [N_CANALES-1:0]             pulso_o,
    output logic [N_CANALES*ANCHO_CONTA-1:0] conta_o,
    output logic [N_CANALES-1:0]             desborde_o
);

    localparam int                     c_ANCHO_DEB  = $clog2(CICLOS_ESTABLE + 1);
    localparam logic [c_ANCHO_DEB-1:0] c_LIMITE_DEB = c_ANCHO_DEB'(CICLOS_ESTABLE - 1);

    generate
        for (genvar i = 0; i < N_CANALES; i++) begin : g_canal
            logic [SYNC_ETAPAS-1:0] sync_q, sync_d;
            logic [c_ANCHO_DEB-1:0] deb_q, deb_d;
            logic                   estado_q, estado_d;
            logic                   pulso_q, pulso_d;
            logic [ANCHO_CONTA-1:0] conta_q, conta_d;
            logic                   desborde_q, desborde_d;
            logic                   w_muestra;
            logic                   w_acepta;
            logic                   w_evento;

            assign w_muestra = sync_q[SYNC_ETAPAS-1];
            // The level is accepted on the edge that would complete the stable run.
            assign w_acepta  = (w_muestra != estado_q) && (deb_q == c_LIMITE_DEB);
            assign w_evento  = w_acepta && ((MODO == 2) ||
                                            ((MODO == 0) &&  w_muestra) ||
                                            ((MODO == 1) && !w_muestra));

            always_comb begin
                sync_d     = {sync_q[SYNC_ETAPAS-2:0], botones_pi[i]};
                deb_d      = '0;
                estado_d   = estado_q;
                pulso_d    = w_evento & habilitar_pi;
                conta_d    = conta_q;
                desborde_d = desborde_q;

                if ((w_muestra != estado_q) && !w_acepta) begin
                    deb_d = deb_q + 1'b1;
                end
                if (w_acepta) begin
                    estado_d = w_muestra;
                end

                if (limpiar_pi[i]) begin
                    conta_d    = '0;
                    desborde_d = 1'b0;
                end else if (w_evento && habilitar_pi) begin
                    conta_d = conta_q + 1'b1;
                    if (&conta_q) begin
                        desborde_d = 1'b1;
                    end
                end
            end

            always_ff @(posedge clk_i or negedge reset_pi) begin
                if (!reset_pi) begin
                    sync_q     <= '0;
                    deb_q      <= '0;
                    estado_q   <= 1'b0;
                    pulso_q    <= 1'b0;
                    conta_q    <= '0;
                    desborde_q <= 1'b0;
                end else begin
                    sync_q     <= sync_d;
                    deb_q      <= deb_d;
                    estado_q   <= estado_d;
                    pulso_q    <= pulso_d;
                    conta_q    <= conta_d;
                    desborde_q <= desborde_d;
                end
            end

            assign estado_o[i]                          = estado_q;
            assign pulso_o[i]                           = pulso_q;
            assign conta_o[i*ANCHO_CONTA +: ANCHO_CONTA] = conta_q;
            assign desborde_o[i]                        = desborde_q;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_acondicionador_botones.sv
`default_nettype none
// ============================================================================
// Module  : tb_acondicionador_botones
// Brief   : random bouncing buttons on three instances (MODO 0/1/2) vs a model
// Rev     : 1.0
// ============================================================================
module tb_acondicionador_botones;

    localparam int N     = 2;
    localparam int SYNC  = 2;
    localparam int EST   = 4;
    localparam int ANCHO = 4;
    localparam int HIST  = SYNC + EST;
    localparam int CICLOS = 4000;

    logic             clk_i = 1'b0;
    logic             reset_pi;
    logic [N-1:0]     botones_pi;
    logic             habilitar_pi;
    logic [N-1:0]     limpiar_pi;
    logic [N-1:0]     est_w   [3];
    logic [N-1:0]     puls_w  [3];
    logic [N-1:0]     desb_w  [3];
    logic [N*ANCHO-1:0] conta_w [3];

    always #5 clk_i = ~clk_i;

    acondicionador_botones #(.N_CANALES(N), .SYNC_ETAPAS(SYNC), .CICLOS_ESTABLE(EST),
                             .ANCHO_CONTA(ANCHO), .MODO(0)) u_dut0 (
        .clk_i(clk_i), .reset_pi(reset_pi), .botones_pi(botones_pi),
        .habilitar_pi(habilitar_pi), .limpiar_pi(limpiar_pi),
        .estado_o(est_w[0]), .pulso_o(puls_w[0]), .conta_o(conta_w[0]), .desborde_o(desb_w[0]));

    acondicionador_botones #(.N_CANALES(N), .SYNC_ETAPAS(SYNC), .CICLOS_ESTABLE(EST),
                             .ANCHO_CONTA(ANCHO), .MODO(1)) u_dut1 (
        .clk_i(clk_i), .reset_pi(reset_pi), .botones_pi(botones_pi),
        .habilitar_pi(habilitar_pi), .limpiar_pi(limpiar_pi),
        .estado_o(est_w[1]), .pulso_o(puls_w[1]), .conta_o(conta_w[1]), .desborde_o(desb_w[1]));

    acondicionador_botones #(.N_CANALES(N), .SYNC_ETAPAS(SYNC), .CICLOS_ESTABLE(EST),
                             .ANCHO_CONTA(ANCHO), .MODO(2)) u_dut2 (
        .clk_i(clk_i), .reset_pi(reset_pi), .botones_pi(botones_pi),
        .habilitar_pi(habilitar_pi), .limpiar_pi(limpiar_pi),
        .estado_o(est_w[2]), .pulso_o(puls_w[2]), .conta_o(conta_w[2]), .desborde_o(desb_w[2]));

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Model: raw samples per channel, newest at index 0; accepted level; events since clear.
    bit m_hist  [N][HIST];
    bit m_est   [N];
    int m_total [3][N];
    bit m_puls  [3][N];
    int hold    [N];
    bit lvl     [N];

    task automatic model_reset();
        for (int c = 0; c < N; c++) begin
            for (int j = 0; j < HIST; j++) m_hist[c][j] = 1'b0;
            m_est[c] = 1'b0;
            for (int m = 0; m < 3; m++) begin
                m_total[m][c] = 0;
                m_puls[m][c]  = 1'b0;
            end
        end
    endtask

    // A level is accepted once the last EST synchronised samples all differ from it.
    task automatic model_step();
        bit acc;
        bit evt;
        for (int c = 0; c < N; c++) begin
            for (int j = HIST - 1; j > 0; j--) m_hist[c][j] = m_hist[c][j-1];
            m_hist[c][0] = botones_pi[c];
            acc = 1'b1;
            for (int j = SYNC; j < HIST; j++) if (m_hist[c][j] == m_est[c]) acc = 1'b0;
            if (acc) m_est[c] = ~m_est[c];
            for (int m = 0; m < 3; m++) begin
                evt = acc && ((m == 2) || (m == 0 && m_est[c]) || (m == 1 && !m_est[c]));
                m_puls[m][c] = evt && habilitar_pi;
                if (limpiar_pi[c])               m_total[m][c] = 0;
                else if (evt && habilitar_pi)    m_total[m][c] = m_total[m][c] + 1;
            end
        end
    endtask

    task automatic compare_all();
        for (int m = 0; m < 3; m++) begin
            for (int c = 0; c < N; c++) begin
                chk($sformatf("estado m%0d c%0d", m, c), int'(est_w[m][c]), int'(m_est[c]));
                chk($sformatf("pulso m%0d c%0d", m, c), int'(puls_w[m][c]), int'(m_puls[m][c]));
                chk($sformatf("conta m%0d c%0d", m, c), int'(conta_w[m][c*ANCHO +: ANCHO]),
                    m_total[m][c] % (1 << ANCHO));
                chk($sformatf("desborde m%0d c%0d", m, c), int'(desb_w[m][c]),
                    int'(m_total[m][c] >= (1 << ANCHO)));
            end
        end
    endtask

    task automatic check_zero(input string tag);
        for (int m = 0; m < 3; m++) begin
            chk($sformatf("%s estado m%0d", tag, m), int'(est_w[m]), 0);
            chk($sformatf("%s pulso m%0d", tag, m), int'(puls_w[m]), 0);
            chk($sformatf("%s conta m%0d", tag, m), int'(conta_w[m]), 0);
            chk($sformatf("%s desborde m%0d", tag, m), int'(desb_w[m]), 0);
        end
    endtask

    initial begin
        reset_pi     = 1'b0;
        botones_pi   = '0;
        habilitar_pi = 1'b1;
        limpiar_pi   = '0;
        for (int c = 0; c < N; c++) begin
            hold[c] = 0;
            lvl[c]  = 1'b0;
        end
        model_reset();
        repeat (2) @(posedge clk_i);
        #1;
        check_zero("reset");
        @(negedge clk_i);
        reset_pi = 1'b1;

        for (int cyc = 0; cyc < CICLOS; cyc++) begin
            @(negedge clk_i);
            for (int c = 0; c < N; c++) begin
                if (hold[c] == 0) begin
                    lvl[c]  = ~lvl[c];
                    hold[c] = int'($urandom_range(1, 8));
                end
                hold[c]--;
                botones_pi[c] = lvl[c];
                limpiar_pi[c] = (cyc >= 2000) && ($urandom_range(0, 24) == 0);
            end
            habilitar_pi = ($urandom_range(0, 9) != 0);

            @(posedge clk_i);
            model_step();
            #1;
            compare_all();

            // Mid-cycle asynchronous reset, released well before the next edge.
            if (cyc == 1500 || cyc == 3500) begin
                #2;
                reset_pi = 1'b0;
                #1;
                check_zero("async_reset");
                model_reset();
                reset_pi = 1'b1;
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
